wb_hold_queue: RTL
==================

Name: wb_hold_queue

Overview:
- Parameterised, multi-entry in-order hold queue for writeback records: register-file write plus CSR write.
- Sits between the MEM/WB pipeline register and the regfile/CSR write ports.
- Absorbs writebacks while the write ports are blocked by a memory stall or port conflict, then drains them in program order.
- Provides a youngest-match forwarding lookup so ID/EX can bypass pending writes.

Parameters:
- XLEN, 64, width of regfile and CSR data.
- DEPTH, 4, number of entries; power of two, >= 2.
- INS_W, 32, width of the carried instruction word.
- CSR_AW, 12, CSR address width.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush; discards all entries.
- enq_valid  in  1  a writeback record is offered.
- enq_ready  out  1  queue accepts a record this cycle.
- enq_ins  in  INS_W  instruction word.
- enq_rd_we  in  1  regfile write enable.
- enq_rd  in  5  destination register.
- enq_rd_data  in  XLEN  regfile write data.
- enq_csr_we  in  1  CSR write enable.
- enq_csr_addr  in  CSR_AW  CSR address.
- enq_csr_data  in  XLEN  CSR write data.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  write ports consume the head this cycle.
- deq_ins, deq_rd_we, deq_rd, deq_rd_data, deq_csr_we, deq_csr_addr, deq_csr_data  out  (as enq_*)  head entry fields.
- fwd_rs  in  5  lookup source register.
- fwd_hit  out  1  a pending entry writes fwd_rs.
- fwd_data  out  XLEN  data from the youngest matching entry.
- count  out  CNT_W  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err_ovf  out  1  sticky: enq_valid was seen while full.

Behaviour:
- Storage is a circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Reset (async, rst=0) clears every entry, pointers, count and err_ovf. Output values under reset:
  - deq_valid=0, all deq_* fields=0.
  - enq_ready=1, empty=1, full=0, count=0.
  - fwd_hit=0, fwd_data=0, err_ovf=0.
  - Reset asserted mid-operation discards all contents immediately.
- enq_ready = !full, combinational. A full queue does not accept an enqueue even if a dequeue happens in the same cycle.
- Enqueue fires when enq_valid && enq_ready. The record is written at wr_ptr and wr_ptr increments.
  - If enq_rd == 0, the stored rd_we is forced to 0.
- Dequeue fires when deq_valid && deq_ready. rd_ptr increments.
- Head fields:
  - deq_valid = !empty.
  - deq_* show the head entry combinationally.
  - When empty, all deq_* are forced to 0 so the write ports see a bubble.
- Latency: a record enqueued at edge N is presented on deq_* after edge N. There is no same-cycle pass-through.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any non-empty, non-full occupancy.
- Dequeue with deq_ready=1 while empty: no effect.
- Enqueue while full:
  - The record is dropped and err_ovf is set.
  - err_ovf stays set until reset or flush.
- Flush:
  - Synchronous; wins over enqueue and dequeue in the same cycle.
  - Next cycle: count=0, pointers=0, err_ovf=0, deq_valid=0.
  - Entry contents are not required to be cleared, but must never be visible while empty.
- Forwarding (combinational over valid entries only):
  - fwd_hit = (fwd_rs != 0) and some valid entry has rd_we=1 and rd=fwd_rs.
  - fwd_data is the rd_data of the youngest such entry, i.e. closest to wr_ptr−1. It is 0 when there is no hit.
  - An entry dequeued this cycle still counts as valid for the lookup.
  - A record being enqueued this cycle is not yet visible to the lookup.
- CSR fields are carried only. The queue performs no CSR lookup.
- count width is CNT_W and never exceeds DEPTH.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with no traffic -> empty=1, enq_ready=1, deq_valid=0, all deq_* = 0, count=0.
- Fill and drain (DEPTH=4): enqueue rd=1..4 with data 0x11,0x22,0x33,0x44 and deq_ready=0.
  - After 4 enqueues -> full=1, enq_ready=0.
  - Then set deq_ready=1 -> deq_rd shows 1,2,3,4 on consecutive cycles, then empty=1.
- Wrap-around with concurrent traffic: hold occupancy at 2 while enqueuing and dequeuing every cycle for 10 cycles.
  - Required: count stays 2, order is preserved across the pointer wrap, and no record is lost.
- Forwarding youngest match:
  - Enqueue rd=5/0xA, rd=7/0xB, rd=5/0xC; fwd_rs=5 -> fwd_hit=1, fwd_data=0xC.
  - fwd_rs=0 with an entry rd=0 enqueued with rd_we=1 -> fwd_hit=0, and that entry's stored rd_we=0.
- Overflow and flush:
  - Enqueue while full -> err_ovf=1 and the record is dropped.
  - Then flush=1 together with enq_valid=1 -> next cycle count=0, err_ovf=0, deq_valid=0.
- Async reset mid-drain: drive rst=0 between clock edges while count=3 -> outputs clear immediately, with no clock edge needed.

Source files
------------

// File: rtl/wb_hold_queue.sv
// rtl/wb_hold_queue.sv - in-order writeback hold queue with youngest-match forwarding
module wb_hold_queue #(
    parameter int XLEN   = 64,
    parameter int DEPTH  = 4,
    parameter int INS_W  = 32,
    parameter int CSR_AW = 12,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [INS_W-1:0]  enq_ins,
    input  logic              enq_rd_we,
    input  logic [4:0]        enq_rd,
    input  logic [XLEN-1:0]   enq_rd_data,
    input  logic              enq_csr_we,
    input  logic [CSR_AW-1:0] enq_csr_addr,
    input  logic [XLEN-1:0]   enq_csr_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [INS_W-1:0]  deq_ins,
    output logic              deq_rd_we,
    output logic [4:0]        deq_rd,
    output logic [XLEN-1:0]   deq_rd_data,
    output logic              deq_csr_we,
    output logic [CSR_AW-1:0] deq_csr_addr,
    output logic [XLEN-1:0]   deq_csr_data,
    input  logic [4:0]        fwd_rs,
    output logic              fwd_hit,
    output logic [XLEN-1:0]   fwd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              err_ovf
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [INS_W-1:0]  r_ins      [DEPTH];
    logic              r_rd_we    [DEPTH];
    logic [4:0]        r_rd       [DEPTH];
    logic [XLEN-1:0]   r_rd_data  [DEPTH];
    logic              r_csr_we   [DEPTH];
    logic [CSR_AW-1:0] r_csr_addr [DEPTH];
    logic [XLEN-1:0]   r_csr_data [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_fwd_idx;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = enq_valid && !w_full;
    assign w_pop     = deq_ready && !w_empty;

    assign enq_ready = !w_full;
    assign deq_valid = !w_empty;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign err_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ins[i]      <= '0;
                r_rd_we[i]    <= 1'b0;
                r_rd[i]       <= '0;
                r_rd_data[i]  <= '0;
                r_csr_we[i]   <= 1'b0;
                r_csr_addr[i] <= '0;
                r_csr_data[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_ins[r_wr_ptr]      <= enq_ins;
                // x0 is never written, so a record targeting it must not forward
                r_rd_we[r_wr_ptr]    <= enq_rd_we && (enq_rd != 5'd0);
                r_rd[r_wr_ptr]       <= enq_rd;
                r_rd_data[r_wr_ptr]  <= enq_rd_data;
                r_csr_we[r_wr_ptr]   <= enq_csr_we;
                r_csr_addr[r_wr_ptr] <= enq_csr_addr;
                r_csr_data[r_wr_ptr] <= enq_csr_data;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (enq_valid && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        deq_ins      = '0;
        deq_rd_we    = 1'b0;
        deq_rd       = '0;
        deq_rd_data  = '0;
        deq_csr_we   = 1'b0;
        deq_csr_addr = '0;
        deq_csr_data = '0;
        if (!w_empty) begin
            deq_ins      = r_ins[r_rd_ptr];
            deq_rd_we    = r_rd_we[r_rd_ptr];
            deq_rd       = r_rd[r_rd_ptr];
            deq_rd_data  = r_rd_data[r_rd_ptr];
            deq_csr_we   = r_csr_we[r_rd_ptr];
            deq_csr_addr = r_csr_addr[r_rd_ptr];
            deq_csr_data = r_csr_data[r_rd_ptr];
        end
    end

    // Walk oldest to youngest so a later (younger) match overrides an earlier one
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        w_fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx = r_rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (fwd_rs != 5'd0) &&
                r_rd_we[w_fwd_idx] && (r_rd[w_fwd_idx] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_rd_data[w_fwd_idx];
            end
        end
    end
endmodule
